// File: rtl/pwm_capture_ip.sv
// ---------------------------------------------------------------------------
// pwm_capture_ip
//   Four-channel PWM input-capture peripheral on the local register bus.
//   Each channel synchronises its cap_in pin, detects rising edges and
//   measures the period and the high time of the waveform in clk cycles.
//   Results are published as read-only registers; sticky valid/ovf flags
//   and a level interrupt report new captures and stalled inputs.
//
// Register map (byte offsets, bits [5:0] of the address are decoded):
//   0x00       CTRL     RW   [3:0] en, [11:8] ie
//   0x04       STATUS   W1C  [3:0] valid, [7:4] ovf
//   0x10+4n    HIGH_n   RO   [CNT_W-1:0]
//   0x20+4n    PERIOD_n RO   [CNT_W-1:0]
//   Everything else reads 0; writes to RO/unmapped offsets are dropped.
//
// Ports:
//   clk, rst            system clock, asynchronous active-high reset
//   cap_in[3:0]         asynchronous PWM inputs, bit n = channel n
//   waddr/wdata/wen/wstrb/wready   write channel (wready tied high)
//   raddr/ren/rdata/rvalid         read channel (one-cycle latency)
//   irq                 level interrupt, OR of (valid & ie), registered
// ---------------------------------------------------------------------------
module pwm_capture_ip #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned STRB_W = DATA_W / 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        cap_in,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              wen,
  input  logic [STRB_W-1:0] wstrb,
  output logic              wready,
  input  logic [ADDR_W-1:0] raddr,
  input  logic              ren,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              irq
);

  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] CNT_MAX_M1 = CNT_MAX - CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  localparam logic [5:0] OFF_CTRL   = 6'h00;
  localparam logic [5:0] OFF_STATUS = 6'h04;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    MEAS = 2'd2
  } ch_state_t;

  // -------------------------------------------------------------------------
  // Register state
  // -------------------------------------------------------------------------
  logic [3:0]       en_q;
  logic [3:0]       ie_q;
  logic [3:0]       valid_q;
  logic [3:0]       ovf_q;
  logic [CNT_W-1:0] high_q   [4];
  logic [CNT_W-1:0] period_q [4];

  // -------------------------------------------------------------------------
  // Input conditioning: two-flop synchroniser plus edge-detect flop
  // -------------------------------------------------------------------------
  logic [3:0] sync1_q;
  logic [3:0] sync2_q;
  logic [3:0] prev_q;
  logic [3:0] sync;
  logic [3:0] rise;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= cap_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign sync = sync2_q;
  assign rise = sync2_q & ~prev_q;

  // -------------------------------------------------------------------------
  // Per-channel measurement FSM
  // -------------------------------------------------------------------------
  ch_state_t        state_q [4];
  ch_state_t        state_d [4];
  logic [CNT_W-1:0] per_q   [4];
  logic [CNT_W-1:0] per_d   [4];
  logic [CNT_W-1:0] hi_q    [4];
  logic [CNT_W-1:0] hi_d    [4];
  logic [3:0]       cap;
  logic [3:0]       ovf_set;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < 4; i++) begin
        state_q[i] <= IDLE;
        per_q[i]   <= '0;
        hi_q[i]    <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < 4; i++) begin
        state_q[i] <= state_d[i];
        per_q[i]   <= per_d[i];
        hi_q[i]    <= hi_d[i];
      end
    end
  end

  // ARM keeps counting the period so that a pin that never toggles after
  // enable still saturates and raises ovf. ovf is flagged once, on the
  // increment that reaches the saturation value; the counter then holds.
  always_comb begin
    state_d = state_q;
    per_d   = per_q;
    hi_d    = hi_q;
    cap     = '0;
    ovf_set = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (!en_q[i]) begin
        state_d[i] = IDLE;
        per_d[i]   = '0;
        hi_d[i]    = '0;
      end else begin
        case (state_q[i])
          IDLE: begin
            state_d[i] = ARM;
            per_d[i]   = '0;
            hi_d[i]    = '0;
          end
          ARM: begin
            if (rise[i]) begin
              state_d[i] = MEAS;
              per_d[i]   = CNT_ONE;
              hi_d[i]    = CNT_ONE;
            end else if (per_q[i] != CNT_MAX) begin
              per_d[i]   = per_q[i] + CNT_ONE;
              ovf_set[i] = (per_q[i] == CNT_MAX_M1);
            end
          end
          MEAS: begin
            if (rise[i]) begin
              cap[i]   = 1'b1;
              per_d[i] = CNT_ONE;
              hi_d[i]  = CNT_ONE;
            end else begin
              if (per_q[i] != CNT_MAX) begin
                per_d[i] = per_q[i] + CNT_ONE;
                if (per_q[i] == CNT_MAX_M1) ovf_set[i] = 1'b1;
              end
              if (sync[i] && (hi_q[i] != CNT_MAX)) begin
                hi_d[i] = hi_q[i] + CNT_ONE;
                if (hi_q[i] == CNT_MAX_M1) ovf_set[i] = 1'b1;
              end
            end
          end
          default: begin
            state_d[i] = IDLE;
            per_d[i]   = '0;
            hi_d[i]    = '0;
          end
        endcase
      end
    end
  end

  // -------------------------------------------------------------------------
  // Write path
  // -------------------------------------------------------------------------
  logic       wr_ctrl;
  logic       wr_status;
  logic [3:0] valid_clr;
  logic [3:0] ovf_clr;

  assign wready    = 1'b1;
  assign wr_ctrl   = wen && (waddr[5:0] == OFF_CTRL);
  assign wr_status = wen && (waddr[5:0] == OFF_STATUS);
  assign valid_clr = (wr_status && wstrb[0]) ? wdata[3:0] : 4'h0;
  assign ovf_clr   = (wr_status && wstrb[0]) ? wdata[7:4] : 4'h0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q <= '0;
      ie_q <= '0;
    end else if (wr_ctrl) begin
      if (wstrb[0]) en_q <= wdata[3:0];
      if (wstrb[1]) ie_q <= wdata[11:8];
    end
  end

  // Hardware set is ORed in after the W1C mask so a coincident set wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      ovf_q   <= '0;
      irq     <= 1'b0;
    end else begin
      valid_q <= (valid_q & ~valid_clr) | cap;
      ovf_q   <= (ovf_q & ~ovf_clr) | ovf_set;
      irq     <= |(valid_q & ie_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < 4; i++) begin
        high_q[i]   <= '0;
        period_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (cap[i]) begin
          high_q[i]   <= hi_q[i];
          period_q[i] <= per_q[i];
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Read path
  // -------------------------------------------------------------------------
  logic [DATA_W-1:0] rd_word;

  always_comb begin
    rd_word = '0;
    case (raddr[5:0])
      6'h00: begin
        rd_word[3:0]  = en_q;
        rd_word[11:8] = ie_q;
      end
      6'h04: begin
        rd_word[3:0] = valid_q;
        rd_word[7:4] = ovf_q;
      end
      6'h10, 6'h14, 6'h18, 6'h1C: rd_word = DATA_W'(high_q[raddr[3:2]]);
      6'h20, 6'h24, 6'h28, 6'h2C: rd_word = DATA_W'(period_q[raddr[3:2]]);
      default: rd_word = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata  <= '0;
      rvalid <= 1'b0;
    end else begin
      rvalid <= ren;
      if (ren) rdata <= rd_word;
    end
  end

  // Address/data bits beyond the decoded fields are intentionally ignored.
  logic unused_ok;
  assign unused_ok = ^{waddr, raddr, wdata, wstrb};

endmodule

// File: tb/tb_pwm_capture_ip.sv
// ---------------------------------------------------------------------------
// tb_pwm_capture_ip
//   Scoreboard bench for pwm_capture_ip. Two instances: the default
//   CNT_W=16 device for measurement/bus behaviour and a CNT_W=8 device for
//   counter saturation. Reads push their expected word into a per-device
//   queue; a monitor per device pops and compares on rvalid.
//   Expected measurements come from the waveform parameters themselves:
//   a pin held high H cycles out of every P gives PERIOD=P, HIGH=H.
// ---------------------------------------------------------------------------
module tb_pwm_capture_ip;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  // main device (CNT_W = 16)
  logic [3:0]  cap_in;
  logic [31:0] waddr, wdata, raddr, rdata;
  logic        wen, ren, wready, rvalid, irq;
  logic [3:0]  wstrb;
  // saturation device (CNT_W = 8)
  logic [3:0]  cap_in8;
  logic [31:0] waddr8, wdata8, raddr8, rdata8;
  logic        wen8, ren8, wready8, rvalid8, irq8;
  logic [3:0]  wstrb8;

  pwm_capture_ip dut (
    .clk(clk), .rst(rst), .cap_in(cap_in),
    .waddr(waddr), .wdata(wdata), .wen(wen), .wstrb(wstrb), .wready(wready),
    .raddr(raddr), .ren(ren), .rdata(rdata), .rvalid(rvalid), .irq(irq)
  );

  pwm_capture_ip #(.CNT_W(8)) dut8 (
    .clk(clk), .rst(rst), .cap_in(cap_in8),
    .waddr(waddr8), .wdata(wdata8), .wen(wen8), .wstrb(wstrb8), .wready(wready8),
    .raddr(raddr8), .ren(ren8), .rdata(rdata8), .rvalid(rvalid8), .irq(irq8)
  );

  int unsigned pcyc = 0;
  always @(posedge clk) pcyc <= pcyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] exp;
    int unsigned due;
    string       tag;
  } rd_exp_t;

  rd_exp_t sb0[$];
  rd_exp_t sb8[$];

  always @(negedge clk) begin : mon0
    rd_exp_t e;
    if (rvalid) begin
      if (sb0.size() == 0) chk("spurious_rvalid", 32'd1, 32'd0);
      else begin
        e = sb0.pop_front();
        chk({e.tag, "_timing"}, pcyc, e.due);
        chk(e.tag, rdata, e.exp);
      end
    end else if (sb0.size() != 0 && sb0[0].due <= pcyc) begin
      e = sb0.pop_front();
      chk({e.tag, "_rvalid"}, 32'd0, 32'd1);
    end
  end

  always @(negedge clk) begin : mon8
    rd_exp_t e;
    if (rvalid8) begin
      if (sb8.size() == 0) chk("spurious_rvalid8", 32'd1, 32'd0);
      else begin
        e = sb8.pop_front();
        chk({e.tag, "_timing"}, pcyc, e.due);
        chk(e.tag, rdata8, e.exp);
      end
    end else if (sb8.size() != 0 && sb8[0].due <= pcyc) begin
      e = sb8.pop_front();
      chk({e.tag, "_rvalid"}, 32'd0, 32'd1);
    end
  end

  // ---------------- waveform generator for the main device ----------------
  int unsigned wp[4];
  int unsigned wh[4];
  int unsigned ph[4];
  int unsigned rise_cyc[4];

  task automatic set_wave(input int n, input int unsigned p, input int unsigned h);
    wp[n] = p;
    wh[n] = h;
    ph[n] = 0;
  endtask

  initial begin : wavegen
    logic v;
    cap_in = '0;
    for (int n = 0; n < 4; n++) begin
      wp[n] = 0; wh[n] = 0; ph[n] = 0; rise_cyc[n] = 0;
    end
    forever begin
      @(posedge clk);
      #1;
      for (int n = 0; n < 4; n++) begin
        v = (wp[n] != 0) && (ph[n] < wh[n]);
        if (v && !cap_in[n]) rise_cyc[n] = pcyc;
        cap_in[n] = v;
        if (wp[n] != 0) ph[n] = (ph[n] + 1 >= wp[n]) ? 0 : ph[n] + 1;
      end
    end
  end

  // ---------------- bus tasks (called at posedge + 1) ----------------
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input bit s, input logic [5:0] a, input logic [31:0] d, input logic [3:0] st);
    if (s) begin waddr8 = {26'd0, a}; wdata8 = d; wstrb8 = st; wen8 = 1'b1; end
    else   begin waddr  = {26'd0, a}; wdata  = d; wstrb  = st; wen  = 1'b1; end
    @(posedge clk);
    #1;
    wen = 1'b0;
    wen8 = 1'b0;
  endtask

  task automatic rd(input bit s, input logic [5:0] a, input logic [31:0] exp, input string tag);
    rd_exp_t e;
    e.exp = exp;
    e.due = pcyc + 1;
    e.tag = tag;
    if (s) begin raddr8 = {26'd0, a}; ren8 = 1'b1; sb8.push_back(e); end
    else   begin raddr  = {26'd0, a}; ren  = 1'b1; sb0.push_back(e); end
    @(posedge clk);
    #1;
    ren = 1'b0;
    ren8 = 1'b0;
  endtask

  int unsigned exp_per[4];
  int unsigned exp_hi[4];

  task automatic check_meas(input string tag);
    for (int n = 0; n < 4; n++) begin
      rd(0, 6'(8'h10 + 4 * n), exp_hi[n],  $sformatf("%s_high%0d", tag, n));
      rd(0, 6'(8'h20 + 4 * n), exp_per[n], $sformatf("%s_period%0d", tag, n));
    end
  endtask

  initial begin : timeout
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin : main
    int unsigned p, h;
    bit found;
    rst = 1'b1;
    wen = 0; ren = 0; waddr = 0; wdata = 0; wstrb = 0; raddr = 0;
    wen8 = 0; ren8 = 0; waddr8 = 0; wdata8 = 0; wstrb8 = 0; raddr8 = 0;
    cap_in8 = 4'b0010;  // channel 1 held high from the start
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wready", 32'(wready), 32'd1);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_rdata",  rdata, 32'd0);
    chk("rst_irq",    32'(irq), 32'd0);
    rst = 1'b0;
    idle(2);

    // Reset state of every decoded and undecoded word
    for (int a = 0; a < 64; a += 4) rd(0, 6'(a), 32'd0, $sformatf("reset_rd_%02h", a));
    rd(1, 6'h04, 32'd0, "reset8_status");
    chk("reset_irq", 32'(irq), 32'd0);

    // Channel 0: 3 high / 7 low
    set_wave(0, 10, 3);
    wr(0, 6'h00, 32'h1, 4'hF);
    idle(40);
    rd(0, 6'h20, 32'd10, "ch0_period_a");
    rd(0, 6'h10, 32'd3,  "ch0_high_a");
    rd(0, 6'h04, 32'h1,  "ch0_status_a");
    idle(7);
    rd(0, 6'h20, 32'd10, "ch0_period_b");
    rd(0, 6'h10, 32'd3,  "ch0_high_b");

    // All four channels at once
    set_wave(0, 10, 5);   exp_per[0] = 10;  exp_hi[0] = 5;
    set_wave(1, 20, 5);   exp_per[1] = 20;  exp_hi[1] = 5;
    set_wave(2, 37, 1);   exp_per[2] = 37;  exp_hi[2] = 1;
    set_wave(3, 256, 255); exp_per[3] = 256; exp_hi[3] = 255;
    wr(0, 6'h00, 32'hF, 4'hF);
    idle(3 * 256 + 30);
    check_meas("multi");
    rd(0, 6'h04, 32'hF, "multi_status");

    // Randomised waveforms
    for (int r = 0; r < 4; r++) begin
      for (int n = 0; n < 4; n++) begin
        p = $urandom_range(80, 2);
        h = $urandom_range(p - 1, 1);
        set_wave(n, p, h);
        exp_per[n] = p;
        exp_hi[n]  = h;
      end
      idle(3 * 80 + 30);
      check_meas($sformatf("rand%0d", r));
    end

    // Interrupt: capture -> valid -> irq one cycle later
    wr(0, 6'h00, 32'h0, 4'hF);
    wr(0, 6'h04, 32'hFF, 4'h1);
    idle(2);
    rd(0, 6'h04, 32'h0, "cleared_status");
    chk("irq_idle", 32'(irq), 32'd0);
    set_wave(0, 10, 3);
    wr(0, 6'h00, 32'h101, 4'hF);
    found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (irq) found = 1;
    end
    chk("irq_seen", 32'(found), 32'd1);
    // pin edge after clock k: two sync flops, edge flop, capture at k+3, irq at k+4
    chk("irq_latency", pcyc - rise_cyc[0], 32'd4);
    @(posedge clk);
    #1;
    rd(0, 6'h04, 32'h1, "irq_status");
    rd(0, 6'h20, 32'd10, "irq_period");

    // W1C of valid drops irq one cycle later
    wr(0, 6'h00, 32'h100, 4'hF);
    idle(1);
    chk("irq_hold", 32'(irq), 32'd1);
    wr(0, 6'h04, 32'h1, 4'h1);
    @(negedge clk);
    chk("irq_lag", 32'(irq), 32'd1);
    @(negedge clk);
    chk("irq_drop", 32'(irq), 32'd0);
    @(posedge clk);
    #1;

    // Disabled channel retains its results and restarts cleanly
    set_wave(0, 16, 4);
    idle(40);
    rd(0, 6'h20, 32'd10, "disabled_period_kept");
    rd(0, 6'h10, 32'd3,  "disabled_high_kept");
    wr(0, 6'h00, 32'h001, 4'hF);
    idle(60);
    rd(0, 6'h20, 32'd16, "reenabled_period");
    rd(0, 6'h10, 32'd4,  "reenabled_high");

    // Byte strobes and read-only writes
    wr(0, 6'h00, 32'h0, 4'hF);
    wr(0, 6'h00, 32'hFFFF, 4'h2);
    rd(0, 6'h00, 32'h0F00, "ctrl_strb_byte1");
    wr(0, 6'h10, 32'hFFFF, 4'hF);
    wr(0, 6'h08, 32'hFFFF, 4'hF);
    rd(0, 6'h10, 32'd4, "ro_write_ignored");
    rd(0, 6'h08, 32'd0, "unmapped_read");
    wr(0, 6'h00, 32'hFFFF, 4'h1);
    rd(0, 6'h00, 32'h0F0F, "ctrl_strb_byte0");

    // Saturation on the CNT_W=8 device: ch1 static high
    wr(1, 6'h00, 32'h2, 4'hF);
    idle(240);
    rd(1, 6'h04, 32'h00, "ovf_not_yet");
    idle(40);
    rd(1, 6'h04, 32'h20, "ovf_set");
    wr(1, 6'h04, 32'h20, 4'h1);
    rd(1, 6'h04, 32'h00, "ovf_w1c");
    wr(1, 6'h00, 32'h0, 4'hF);
    wr(1, 6'h00, 32'h2, 4'hF);
    // one IDLE cycle, then 255 counting cycles in ARM: saturates 256 clocks after enable
    idle(255);
    wr(1, 6'h04, 32'h20, 4'h1);
    rd(1, 6'h04, 32'h20, "ovf_set_wins");

    // Asynchronous reset in the middle of measurement
    idle(60);
    rd(0, 6'h20, 32'd16, "pre_rst_period");
    idle(1);
    chk("pre_rst_irq", 32'(irq), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_rdata",  rdata, 32'd0);
    chk("async_rst_rvalid", 32'(rvalid), 32'd0);
    chk("async_rst_irq",    32'(irq), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2);
    for (int a = 0; a < 64; a += 4) rd(0, 6'(a), 32'd0, $sformatf("post_rst_rd_%02h", a));
    idle(300);
    rd(0, 6'h04, 32'h0, "post_rst_idle_status");
    rd(1, 6'h04, 32'h0, "post_rst_idle_status8");

    idle(5);
    chk("sb0_drained", sb0.size(), 32'd0);
    chk("sb8_drained", sb8.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
